// File: rtl/countdown_timer_if.sv
// ============================================================================
// Module      : countdown_timer_if
// Description : Control/status bundle for the hh:mm:ss countdown timer.
//               The master drives the commands and the preset; the slave
//               (the timer) returns the remaining time and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_timer_if;
    logic       tick;
    logic       clear;
    logic       load;
    logic [7:0] load_hr;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic       ack;
    logic [7:0] hrs;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       alarm;
    logic       done;

    modport master (
        output tick, clear, load, load_hr, load_min, load_sec, start, pause, ack,
        input  hrs, min, sec, running, alarm, done
    );

    modport slave (
        input  tick, clear, load, load_hr, load_min, load_sec, start, pause, ack,
        output hrs, min, sec, running, alarm, done
    );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module      : countdown_timer
// Description : Hours/minutes/seconds countdown timer. Loads a clamped preset,
//               decrements once per tick with borrow across the fields and
//               raises a latched alarm at 00:00:00 that clears on ack or after
//               ALARM_TICKS ticks (ALARM_TICKS = 0 waits for ack only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int HR_MAX      = 23,
    parameter int ALARM_TICKS = 30
) (
    input  logic             clk,
    input  logic             reset,
    countdown_timer_if.slave bus
);

    localparam logic [7:0] c_hr_max    = 8'(HR_MAX);
    localparam logic [7:0] c_field_max = 8'd59;
    // Counter only has to reach ALARM_TICKS-1; keep at least one bit so the
    // declaration stays legal when the timeout is disabled.
    localparam int         CNT_W       = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [7:0]       hrs_q,       hrs_d;
    logic [7:0]       min_q,       min_d;
    logic [7:0]       sec_q,       sec_d;
    logic             running_q,   running_d;
    logic             alarm_q,     alarm_d;
    logic             done_q,      done_d;
    logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;

    logic [7:0]       dec_hrs;
    logic [7:0]       dec_min;
    logic [7:0]       dec_sec;
    logic             dec_zero;
    logic             time_zero;
    logic             alarm_limit_hit;

    assign time_zero = (hrs_q == 8'd0) && (min_q == 8'd0) && (sec_q == 8'd0);

    // The alarm timeout comparator only exists when a timeout is configured.
    if (ALARM_TICKS > 0) begin : g_alarm_timeout
        localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ALARM_TICKS - 1);
        assign alarm_limit_hit = (alarm_cnt_q == c_cnt_last);
    end else begin : g_alarm_ack_only
        assign alarm_limit_hit = 1'b0;
    end

    // One-second decrement with borrow; only consulted while running, where
    // the time is known to be non-zero so no field can wrap below zero.
    always_comb begin
        dec_hrs = hrs_q;
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != 8'd0) begin
            dec_sec = sec_q - 8'd1;
        end else if (min_q != 8'd0) begin
            dec_sec = c_field_max;
            dec_min = min_q - 8'd1;
        end else if (hrs_q != 8'd0) begin
            dec_sec = c_field_max;
            dec_min = c_field_max;
            dec_hrs = hrs_q - 8'd1;
        end
        dec_zero = (dec_hrs == 8'd0) && (dec_min == 8'd0) && (dec_sec == 8'd0);
    end

    // Next-state and next-output logic; commands are resolved in the order
    // clear, load, ack, pause, start, tick, and each is only honoured in the
    // states where it has a meaning.
    always_comb begin
        state_d     = state_q;
        hrs_d       = hrs_q;
        min_d       = min_q;
        sec_d       = sec_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;

        if (bus.clear) begin
            state_d = ST_IDLE;
            hrs_d   = 8'd0;
            min_d   = 8'd0;
            sec_d   = 8'd0;
        end else if (bus.load && (state_q != ST_RUN)) begin
            // Out-of-range presets saturate rather than being rejected.
            state_d = ST_IDLE;
            hrs_d   = (bus.load_hr  > c_hr_max)    ? c_hr_max    : bus.load_hr;
            min_d   = (bus.load_min > c_field_max) ? c_field_max : bus.load_min;
            sec_d   = (bus.load_sec > c_field_max) ? c_field_max : bus.load_sec;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    // A tick arriving with start is swallowed: RUN is entered
                    // this edge and the first decrement waits for the next tick.
                    if (bus.start && !time_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick) begin
                        hrs_d = dec_hrs;
                        min_d = dec_min;
                        sec_d = dec_sec;
                        if (dec_zero) begin
                            state_d     = ST_EXPIRED;
                            done_d      = 1'b1;
                            alarm_cnt_d = '0;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (bus.ack) begin
                        state_d = ST_IDLE;
                    end else if (bus.tick) begin
                        if (alarm_limit_hit) begin
                            state_d = ST_IDLE;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_EXPIRED);
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hrs_q       <= 8'd0;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            done_q      <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hrs_q       <= hrs_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
            done_q      <= done_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign bus.hrs     = hrs_q;
    assign bus.min     = min_q;
    assign bus.sec     = sec_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;
    assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer: directed vector
//               table, multi-cycle corner sequences and a randomized run
//               against a total-seconds reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam int HR_MAX      = 23;
    localparam int ALARM_TICKS = 30;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    countdown_timer_if u_if ();

    countdown_timer #(
        .HR_MAX      (HR_MAX),
        .ALARM_TICKS (ALARM_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       tick, clear, load;
        logic [7:0] lh, lm, ls;
        logic       start, pause, ack;
        logic [7:0] eh, em, es;
        logic       er, ea, ed;
    } vec_t;

    vec_t vecs[21];

    // reference model state: remaining time as a single seconds count
    int m_total;
    int m_mode;
    int m_cnt;
    bit m_done;

    function automatic vec_t mk(input logic tk, cl, ld, input int lh, lm, ls,
                                input logic st, pa, ak, input int eh, em, es,
                                input logic er, ea, ed);
        vec_t v;
        v.tick = tk; v.clear = cl; v.load = ld;
        v.lh = 8'(lh); v.lm = 8'(lm); v.ls = 8'(ls);
        v.start = st; v.pause = pa; v.ack = ak;
        v.eh = 8'(eh); v.em = 8'(em); v.es = 8'(es);
        v.er = er; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic drive(input logic tk, cl, ld, input logic [7:0] lh, lm, ls,
                         input logic st, pa, ak);
        u_if.tick = tk; u_if.clear = cl; u_if.load = ld;
        u_if.load_hr = lh; u_if.load_min = lm; u_if.load_sec = ls;
        u_if.start = st; u_if.pause = pa; u_if.ack = ak;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input int eh, em, es,
                         input logic er, ea, ed);
        n_cmp++;
        if (u_if.hrs !== 8'(eh) || u_if.min !== 8'(em) || u_if.sec !== 8'(es) ||
            u_if.running !== er || u_if.alarm !== ea || u_if.done !== ed) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d:%0d:%0d run=%b alarm=%b done=%b, want %0d:%0d:%0d run=%b alarm=%b done=%b",
                     nm, idx, u_if.hrs, u_if.min, u_if.sec, u_if.running, u_if.alarm, u_if.done,
                     eh, em, es, er, ea, ed);
        end
    endtask

    // one clock of the high-level model, seconds arithmetic only
    task automatic model_step(input logic tk, cl, ld, input int lh, lm, ls,
                              input logic st, pa, ak);
        m_done = 0;
        if (cl) begin
            m_total = 0;
            m_mode  = M_IDLE;
        end else if (ld && m_mode != M_RUN) begin
            m_total = (lh > HR_MAX ? HR_MAX : lh) * 3600 + (lm > 59 ? 59 : lm) * 60
                      + (ls > 59 ? 59 : ls);
            m_mode  = M_IDLE;
        end else if (m_mode == M_EXP) begin
            if (ak) m_mode = M_IDLE;
            else if (tk) begin
                m_cnt++;
                if (m_cnt == ALARM_TICKS) m_mode = M_IDLE;
            end
        end else if (m_mode == M_RUN) begin
            if (pa) m_mode = M_PAUSE;
            else if (tk) begin
                m_total--;
                if (m_total == 0) begin
                    m_mode = M_EXP;
                    m_cnt  = 0;
                    m_done = 1;
                end
            end
        end else if (st && m_total != 0) begin
            m_mode = M_RUN;
        end
    endtask

    initial begin
        // tick clear load  hr  min sec  start pause ack | hh mm ss run alm done
        vecs[0]  = mk(0, 0, 1, 30, 75, 60, 0, 0, 0, 23, 59, 59, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,  0,  0,  0, 1, 0, 0, 23, 59, 59, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1,  1,  2,  3, 0, 0, 0, 23, 59, 59, 1, 0, 0);
        vecs[3]  = mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 23, 59, 58, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0,  0,  0,  0, 0, 1, 0, 23, 59, 58, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0,  0,  0,  0, 1, 0, 0, 23, 59, 58, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 23, 59, 57, 1, 0, 0);
        vecs[7]  = mk(1, 1, 1,  5,  5,  5, 0, 0, 0,  0,  0,  0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 0,  0,  0,  0, 1, 0, 0,  0,  0,  0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1,  1,  0,  0, 0, 0, 0,  1,  0,  0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0,  0,  0,  0, 1, 0, 0,  1,  0,  0, 1, 0, 0);
        vecs[11] = mk(1, 0, 0,  0,  0,  0, 0, 0, 0,  0, 59, 59, 1, 0, 0);
        vecs[12] = mk(1, 0, 0,  0,  0,  0, 0, 0, 0,  0, 59, 58, 1, 0, 0);
        vecs[13] = mk(0, 0, 0,  0,  0,  0, 0, 1, 0,  0, 59, 58, 0, 0, 0);
        vecs[14] = mk(0, 0, 1,  0,  0,  2, 0, 0, 0,  0,  0,  2, 0, 0, 0);
        vecs[15] = mk(0, 0, 0,  0,  0,  0, 1, 0, 0,  0,  0,  2, 1, 0, 0);
        vecs[16] = mk(1, 0, 0,  0,  0,  0, 0, 0, 0,  0,  0,  1, 1, 0, 0);
        vecs[17] = mk(1, 0, 0,  0,  0,  0, 0, 0, 0,  0,  0,  0, 0, 1, 1);
        vecs[18] = mk(0, 0, 0,  0,  0,  0, 0, 0, 0,  0,  0,  0, 0, 1, 0);
        vecs[19] = mk(0, 0, 0,  0,  0,  0, 1, 0, 0,  0,  0,  0, 0, 1, 0);
        vecs[20] = mk(0, 0, 0,  0,  0,  0, 0, 0, 1,  0,  0,  0, 0, 0, 0);

        idle_in();
        reset = 1'b1;
        step();
        step();
        check("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].tick, vecs[i].clear, vecs[i].load, vecs[i].lh, vecs[i].lm,
                  vecs[i].ls, vecs[i].start, vecs[i].pause, vecs[i].ack);
            step();
            check("vec", i, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ea, vecs[i].ed);
        end

        // 00:01:05 counted all the way down, ticks interleaved with quiet cycles
        drive(0, 0, 1, 8'd0, 8'd1, 8'd5, 0, 0, 0); step();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0); step();
        check("run65_start", 0, 0, 1, 5, 1, 0, 0);
        for (int i = 1; i <= 65; i++) begin
            idle_in(); u_if.tick = 1'b1; step();
            if (i < 65) check("run65_tick", i, 0, (65 - i) / 60, (65 - i) % 60, 1, 0, 0);
            else        check("run65_expire", i, 0, 0, 0, 0, 1, 1);
            idle_in(); step();
            if (i < 65) check("run65_hold", i, 0, (65 - i) / 60, (65 - i) % 60, 1, 0, 0);
            else        check("run65_done_drop", i, 0, 0, 0, 0, 1, 0);
        end

        // alarm timeout: stays up through ALARM_TICKS-1 ticks, drops on the last
        for (int i = 1; i <= ALARM_TICKS; i++) begin
            idle_in(); u_if.tick = 1'b1; step();
            if (i < ALARM_TICKS) check("alarm_tick", i, 0, 0, 0, 0, 1, 0);
            else                 check("alarm_timeout", i, 0, 0, 0, 0, 0, 0);
        end

        // async reset mid-run at 00:10:00
        drive(0, 0, 1, 8'd0, 8'd10, 8'd0, 0, 0, 0); step();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0); step();
        check("rst_pre", 0, 0, 10, 0, 1, 0, 0);
        idle_in();
        #2 reset = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 0, 0, 0, 0);
        u_if.tick = 1'b1;
        step();
        check("rst_held", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        u_if.start = 1'b1;
        step();
        check("rst_after", 0, 0, 0, 0, 0, 0, 0);

        // clear while the alarm is up
        drive(0, 0, 1, 8'd0, 8'd0, 8'd1, 0, 0, 0); step();
        drive(0, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0); step();
        idle_in(); u_if.tick = 1'b1; step();
        check("clr_expired", 0, 0, 0, 0, 0, 1, 1);
        idle_in(); u_if.clear = 1'b1; step();
        check("clr_idle", 0, 0, 0, 0, 0, 0, 0);

        // randomized run against the reference model
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_total = 0; m_mode = M_IDLE; m_cnt = 0; m_done = 0;
        for (int i = 0; i < 4000; i++) begin
            logic tk, cl, ld, st, pa, ak;
            int   lh, lm, ls;
            tk = ($urandom_range(0, 1) == 0);
            cl = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 9) == 0);
            pa = ($urandom_range(0, 24) == 0);
            ak = ($urandom_range(0, 29) == 0);
            lh = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : 0;
            lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 2));
            ls = int'($urandom_range(0, 70));
            drive(tk, cl, ld, 8'(lh), 8'(lm), 8'(ls), st, pa, ak);
            model_step(tk, cl, ld, lh, lm, ls, st, pa, ak);
            step();
            check("rand", i, m_total / 3600, (m_total / 60) % 60, m_total % 60,
                  m_mode == M_RUN, m_mode == M_EXP, m_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
